if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: the program counter, the next-PC select, and the IF/ID pipeline register.
- Drives the instruction-memory address and captures the returned word into IF/ID.
- Presents OpCode/Funct slices directly to the downstream Control decoder.
- Takes redirects from ID (j/jal/jr/jalr via PCSrc) and from EX (taken branch), and takes stall from the hazard unit.

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the program counter and the IF/ID pipeline register. It selects the
// next PC from four sources: sequential, J-type jump, register jump, or
// EX-stage branch.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hazard-unit hold: freeze PC and IF/ID
//   PCSrc          ID-stage jump select (00 seq, 01 j/jal, 10 jr/jalr, 11 seq)
//   jr_addr        forwarded rs value, used as-is for PCSrc=10
//   branch_taken   EX-stage branch resolved taken
//   branch_target  EX-stage branch address
//   imem_addr      current PC, driven combinationally to instruction memory
//   imem_rdata     instruction word returned by memory in the same cycle
//   if_id_instr    registered instruction
//   if_id_pc_plus4 registered PC+4 of that instruction
//   if_id_valid    1 = real instruction, 0 = bubble
//   OpCode/Funct   slices of if_id_instr for the Control decoder
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] jr_addr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q,  pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] j_target;

    // Unsigned 32-bit add; wraps silently past 32'hFFFF_FFFC.
    assign pc_plus4 = pc_q + 32'd4;

    // The jump sits in ID, so its target comes from the IF/ID copy.
    assign j_target = {pcp4_q[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;

        if (branch_taken) begin
            // The ID instruction is on the wrong path, so this beats stall and jumps.
            pc_d    = branch_target;
            instr_d = NOP_INSTR;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (stall) begin
            // Hold everything. A pending jump stays in ID and re-presents later.
        end else if (valid_q && (PCSrc == 2'b01)) begin
            pc_d    = j_target;
            instr_d = NOP_INSTR;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (valid_q && (PCSrc == 2'b10)) begin
            pc_d    = jr_addr;
            instr_d = NOP_INSTR;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else begin
            // Sequential path. PCSrc=11, or any PCSrc from a bubble, lands here.
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pcp4_q;
    assign if_id_valid    = valid_q;
    assign OpCode         = instr_q[31:26];
    assign Funct          = instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- scoreboard bench for if_stage.
// The stimulus process drives inputs on the falling edge. It steps a
// behavioural model of the fetch rules and pushes the expected post-edge state
// into a queue. The monitor pops one entry after each rising edge and compares
// it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [1:0]  PCSrc;
    logic [31:0] jr_addr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .PCSrc(PCSrc),
        .jr_addr(jr_addr), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .OpCode(OpCode), .Funct(Funct)
    );

    always #5 clk = ~clk;

    // Instruction memory: a small directed program, then a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;   // addi $t0,$0,5
        if (a == 32'h0040_0004) return 32'h0810_0008;   // j 0x0040_0020
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid;

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcp4 = 32'd0; m_valid = 1'b0;
    endtask

    task automatic model_bubble(input logic [31:0] new_pc);
        m_pc = new_pc; m_instr = NOP_INSTR; m_pcp4 = 32'd0; m_valid = 1'b0;
    endtask

    // Fetch rules in priority order: branch, stall, jump (valid only), sequential.
    task automatic model_step(input logic st, input logic [1:0] pcs,
                              input logic [31:0] jra, input logic bt,
                              input logic [31:0] btgt);
        logic [31:0] seq_pc;
        seq_pc = m_pc + 32'd4;
        if (bt)
            model_bubble(btgt);
        else if (st)
            ;
        else if (m_valid && pcs == 2'd1)
            model_bubble((m_pcp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2));
        else if (m_valid && pcs == 2'd2)
            model_bubble(jra);
        else begin
            m_instr = mem_word(m_pc);
            m_pcp4  = seq_pc;
            m_pc    = seq_pc;
            m_valid = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, push the expectation, then move to the next falling edge.
    task automatic step(input logic st, input logic [1:0] pcs, input logic [31:0] jra,
                        input logic bt, input logic [31:0] btgt);
        exp_t e;
        stall = st; PCSrc = pcs; jr_addr = jra; branch_taken = bt; branch_target = btgt;
        model_step(st, pcs, jra, bt, btgt);
        e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Pulse reset between edges. Outputs must change at once, with no clock edge.
    task automatic reset_pulse();
        PCSrc = 2'b01;
        #1 reset_n = 1'b0;
        #1;
        check32("async_rst_pc", imem_addr, RESET_PC);
        check32("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
        check32("async_rst_instr", if_id_instr, NOP_INSTR);
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    // Monitor: one scoreboard comparison after each rising edge that has an expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_txn++;
            n_checks++;
            if (imem_addr === e.pc && if_id_instr === e.instr &&
                if_id_pc_plus4 === e.pcp4 && if_id_valid === e.valid &&
                OpCode === e.instr[31:26] && Funct === e.instr[5:0]) begin
                n_pass++;
                $display("txn %0d ok pc=%h instr=%h pc4=%h v=%0b",
                         n_txn, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid);
            end else begin
                $display("FAIL txn %0d: got pc=%h instr=%h pc4=%h v=%0b op=%h fn=%h; expected pc=%h instr=%h pc4=%h v=%0b",
                         n_txn, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
                         OpCode, Funct, e.pc, e.instr, e.pcp4, e.valid);
            end
        end
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; PCSrc = 2'b00; jr_addr = 32'd0;
        branch_taken = 1'b0; branch_target = 32'd0;
        model_reset();

        // Outputs hold their reset values across edges while reset is low.
        repeat (2) @(negedge clk);
        check32("rst_pc", imem_addr, 32'h0040_0000);
        check32("rst_pc4", if_id_pc_plus4, 32'd0);
        check32("rst_valid", {31'd0, if_id_valid}, 32'd0);
        reset_n = 1'b1;

        // First fetch.
        step(0, 2'b00, 0, 0, 0);
        check32("first_instr", if_id_instr, 32'h2008_0005);
        check32("first_op", {26'd0, OpCode}, 32'h08);
        check32("first_pc", imem_addr, 32'h0040_0004);
        step(0, 2'b00, 0, 0, 0);                        // j now sits in IF/ID
        check32("j_in_idif_pc4", if_id_pc_plus4, 32'h0040_0008);
        step(0, 2'b01, 0, 0, 0);                        // take j
        check32("j_pc", imem_addr, 32'h0040_0020);
        check32("j_bubble_op", {26'd0, OpCode}, 32'd0);
        step(0, 2'b00, 0, 0, 0);                        // fetch from jump target
        check32("j_next_pc4", if_id_pc_plus4, 32'h0040_0024);

        // A stall suppresses jr for two edges, then jr takes effect.
        step(1, 2'b10, 32'h0040_1000, 0, 0);
        step(1, 2'b10, 32'h0040_1000, 0, 0);
        check32("stall_hold_pc", imem_addr, 32'h0040_0024);
        step(0, 2'b10, 32'h0040_1000, 0, 0);
        check32("jr_pc", imem_addr, 32'h0040_1000);
        step(0, 2'b10, 32'h0000_0777, 0, 0);            // PCSrc from a bubble is ignored
        check32("bubble_pcsrc_ignored", imem_addr, 32'h0040_1004);

        // The branch wins over both stall and PCSrc.
        step(1, 2'b01, 0, 1, 32'h0040_0100);
        check32("br_pc", imem_addr, 32'h0040_0100);
        check32("br_valid", {31'd0, if_id_valid}, 32'd0);

        // PC+4 wraps past the top of the address space.
        step(0, 2'b00, 0, 1, 32'hFFFF_FFFC);
        step(0, 2'b00, 0, 0, 0);
        check32("wrap_pc", imem_addr, 32'h0000_0000);
        check32("wrap_pc4", if_id_pc_plus4, 32'h0000_0000);
        check32("wrap_valid", {31'd0, if_id_valid}, 32'd1);

        // Mid-stream reset drops a pending jump.
        step(0, 2'b00, 0, 0, 0);
        reset_pulse();
        step(0, 2'b01, 0, 0, 0);
        check32("post_rst_pc", imem_addr, 32'h0040_0004);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic        st, bt;
            logic [1:0]  pcs;
            st  = ($urandom_range(0, 99) < 20);
            bt  = ($urandom_range(0, 99) < 10);
            pcs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) reset_pulse();
            step(st, pcs, $urandom, bt, $urandom);
        end

        @(negedge clk);
        check32("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
